// File: rtl/btn_sw_conditioner.sv
// Button/switch front end: 2-flop sync, tick-based debounce, press/release/change pulses.
// Define BTN_REPEAT_EN to add hold-to-auto-repeat on btn_press.
module btn_sw_conditioner #(
    parameter int unsigned N_BTN        = 4,
    parameter int unsigned N_SW         = 8,
    parameter int unsigned TICK_DIV     = 100000,
    parameter int unsigned DB_TICKS     = 10,
    parameter int unsigned REPEAT_DELAY = 500,
    parameter int unsigned REPEAT_RATE  = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_level,
    output logic             sw_change,
    output logic             tick
);
    localparam int unsigned N_IN = N_BTN + N_SW;
    localparam int unsigned PW   = $clog2(TICK_DIV);
    localparam int unsigned CW   = $clog2(DB_TICKS + 1);

    if (TICK_DIV < 2) begin : g_chk_tick
        $error("TICK_DIV must be at least 2");
    end
    if (DB_TICKS < 1) begin : g_chk_db
        $error("DB_TICKS must be at least 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_chk_rep
        $error("REPEAT_DELAY and REPEAT_RATE must be at least 1");
    end

`ifdef BTN_REPEAT_EN
    typedef enum logic [1:0] {StReleased, StPressed, StRepeat} btn_state_e;
    localparam int unsigned HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HW   = $clog2(HMAX + 1);
    logic [HW-1:0] hold_q [N_BTN];
`else
    typedef enum logic {StReleased, StPressed} btn_state_e;
`endif

    logic [N_IN-1:0]  raw, meta_q, sync_q, level_q, flip;
    logic [CW-1:0]    cnt_q [N_IN];
    logic [PW-1:0]    presc_q;
    logic [N_BTN-1:0] rise, fall;
    btn_state_e       state_q [N_BTN];

    assign raw = {sw_raw, btn_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            tick    <= 1'b0;
        end else begin
            presc_q <= (presc_q == PW'(TICK_DIV - 1)) ? '0 : presc_q + PW'(1);
            // Registered: high exactly while presc_q == TICK_DIV-1.
            tick    <= (presc_q == PW'(TICK_DIV - 2));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_IN; i++) begin
            flip[i] = tick && (sync_q[i] != level_q[i]) && (cnt_q[i] == CW'(DB_TICKS - 1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= '0;
            sync_q  <= '0;
            level_q <= '0;
            for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
        end else begin
            meta_q <= raw;
            sync_q <= meta_q;
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (sync_q[i] == level_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (tick) begin
                    if (flip[i]) begin
                        level_q[i] <= sync_q[i];
                        cnt_q[i]   <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + CW'(1);
                    end
                end
            end
        end
    end

    assign btn_level = level_q[N_BTN-1:0];
    assign sw_level  = level_q[N_IN-1:N_BTN];
    assign rise      = flip[N_BTN-1:0] & sync_q[N_BTN-1:0];
    assign fall      = flip[N_BTN-1:0] & ~sync_q[N_BTN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sw_change <= 1'b0;
        else     sw_change <= |flip[N_IN-1:N_BTN];
    end

    // Pulses are registered on the same edge that flips btn_level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_press   <= '0;
            btn_release <= '0;
            for (int unsigned i = 0; i < N_BTN; i++) begin
                state_q[i] <= StReleased;
`ifdef BTN_REPEAT_EN
                hold_q[i]  <= '0;
`endif
            end
        end else begin
            for (int unsigned i = 0; i < N_BTN; i++) begin
                btn_press[i]   <= 1'b0;
                btn_release[i] <= 1'b0;
                unique case (state_q[i])
                    StReleased: begin
                        if (rise[i]) begin
                            state_q[i]   <= StPressed;
                            btn_press[i] <= 1'b1;
`ifdef BTN_REPEAT_EN
                            hold_q[i]    <= '0;
`endif
                        end
                    end
                    StPressed: begin
                        if (fall[i]) begin
                            state_q[i]     <= StReleased;
                            btn_release[i] <= 1'b1;
`ifdef BTN_REPEAT_EN
                            hold_q[i]      <= '0;
                        end else if (tick) begin
                            if (hold_q[i] == HW'(REPEAT_DELAY - 1)) begin
                                state_q[i]   <= StRepeat;
                                btn_press[i] <= 1'b1;
                                hold_q[i]    <= '0;
                            end else begin
                                hold_q[i] <= hold_q[i] + HW'(1);
                            end
`endif
                        end
                    end
`ifdef BTN_REPEAT_EN
                    StRepeat: begin
                        if (fall[i]) begin
                            state_q[i]     <= StReleased;
                            btn_release[i] <= 1'b1;
                            hold_q[i]      <= '0;
                        end else if (tick) begin
                            if (hold_q[i] == HW'(REPEAT_RATE - 1)) begin
                                btn_press[i] <= 1'b1;
                                hold_q[i]    <= '0;
                            end else begin
                                hold_q[i] <= hold_q[i] + HW'(1);
                            end
                        end
                    end
`endif
                    default: state_q[i] <= StReleased;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Directed bench for btn_sw_conditioner with TICK_DIV=4, DB_TICKS=3 (repeat 5/2 ticks).
module tb_btn_sw_conditioner;
    localparam int unsigned N_BTN = 4;
    localparam int unsigned N_SW  = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level, btn_press, btn_release;
    logic [N_SW-1:0]  sw_level;
    logic             sw_change, tick;

    int total = 0;
    int bad   = 0;
    int press_cnt [N_BTN] = '{0, 0, 0, 0};
    int rel_cnt   [N_BTN] = '{0, 0, 0, 0};
    int both_cnt   = 0;
    int sw_chg_cnt = 0;
    int cyc        = 0;
    int rep_stamp [$];

    always #5 clk = ~clk;

    btn_sw_conditioner #(
        .N_BTN(N_BTN), .N_SW(N_SW), .TICK_DIV(4), .DB_TICKS(3),
        .REPEAT_DELAY(5), .REPEAT_RATE(2)
    ) dut (
        .clk(clk), .rst(rst), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .sw_level(sw_level), .sw_change(sw_change), .tick(tick)
    );

    // Pulse monitor, sampled mid-cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < N_BTN; i++) begin
            if (btn_press[i] === 1'b1)   press_cnt[i] <= press_cnt[i] + 1;
            if (btn_release[i] === 1'b1) rel_cnt[i] <= rel_cnt[i] + 1;
        end
        if ((btn_press & btn_release) != '0) both_cnt <= both_cnt + 1;
        if (btn_press[3] === 1'b1) rep_stamp.push_back(cyc);
        if (sw_change === 1'b1) sw_chg_cnt <= sw_chg_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
        total++;
        assert (obs >= lo && obs <= hi) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_btn(input int b, input logic val, output int n);
        n = 0;
        while (btn_level[b] !== val && n < 40) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_sw(input logic [N_SW-1:0] val, output int n);
        n = 0;
        while (sw_level !== val && n < 40) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        int n;
        int pc;
        rst     = 1'b1;
        btn_raw = '0;
        sw_raw  = '0;
        step(3);
        chk("rst_btn_level", 32'(btn_level), 0);
        chk("rst_btn_press", 32'(btn_press), 0);
        chk("rst_btn_release", 32'(btn_release), 0);
        chk("rst_sw_level", 32'(sw_level), 0);
        chk("rst_sw_change", 32'(sw_change), 0);
        chk("rst_tick", 32'(tick), 0);

        // Clean press on button 0, raw applied as reset releases.
        rst     = 1'b0;
        btn_raw = 4'b0001;
        wait_btn(0, 1'b1, n);
        chk_rng("press0_latency", n, 11, 14);
        step(3);
        chk("press0_count", press_cnt[0], 1);
        chk("press0_others_level", 32'(btn_level[3:1]), 0);
        chk("press0_others_press", press_cnt[1] + press_cnt[2] + press_cnt[3], 0);

        // Tick period and width.
        n = 0;
        while (tick !== 1'b1 && n < 10) begin step(1); n++; end
        step(1);
        chk("tick_width", 32'(tick), 0);
        n = 1;
        while (tick !== 1'b1 && n < 10) begin step(1); n++; end
        chk("tick_period", n, 4);

        // Bounce on button 1: 5-cycle toggles never cover three ticks.
        for (int k = 0; k < 8; k++) begin
            btn_raw[1] = ~btn_raw[1];
            step(5);
        end
        chk("bounce_no_level", 32'(btn_level[1]), 0);
        btn_raw[1] = 1'b1;
        wait_btn(1, 1'b1, n);
        step(3);
        chk("bounce_level", 32'(btn_level[1]), 1);
        chk("bounce_press_count", press_cnt[1], 1);

        // 6-cycle glitch on button 2.
        btn_raw[2] = 1'b1;
        step(6);
        btn_raw[2] = 1'b0;
        step(20);
        chk("glitch_level", 32'(btn_level[2]), 0);
        chk("glitch_press", press_cnt[2], 0);
        chk("glitch_release", rel_cnt[2], 0);

        // Release button 0.
        btn_raw[0] = 1'b0;
        wait_btn(0, 1'b0, n);
        chk_rng("release0_latency", n, 11, 14);
        step(3);
        chk("release0_count", rel_cnt[0], 1);
        chk("release0_no_press", press_cnt[0], 1);

        // Switches: 00 -> A5.
        sw_raw = 8'hA5;
        wait_sw(8'hA5, n);
        chk_rng("sw_a5_latency", n, 11, 14);
        step(20);
        chk("sw_a5_level", 32'(sw_level), 32'hA5);
        chk("sw_a5_change_count", sw_chg_cnt, 1);

        // A5 -> 5A interrupted by reset; button 1 held through reset.
        sw_raw = 8'h5A;
        step(6);
        chk("sw_mid_debounce", 32'(sw_level), 32'hA5);
        rst = 1'b1;
        #1;
        chk("sw_async_reset", 32'(sw_level), 0);
        chk("btn_async_reset", 32'(btn_level), 0);
        step(2);
        rst = 1'b0;
        wait_sw(8'h5A, n);
        chk_rng("sw_5a_latency", n, 11, 14);
        step(3);
        chk("sw_5a_level", 32'(sw_level), 32'h5A);
        chk("sw_change_total", sw_chg_cnt, 2);
        chk("held_through_reset_level", 32'(btn_level[1]), 1);
        chk("held_through_reset_press", press_cnt[1], 2);

        // Hold button 3 for 40 ticks.
        rep_stamp.delete();
        btn_raw[3] = 1'b1;
        wait_btn(3, 1'b1, n);
        chk_rng("press3_latency", n, 11, 14);
        step(160 - n);
        btn_raw[3] = 1'b0;
        wait_btn(3, 1'b0, n);
        chk_rng("release3_latency", n, 11, 14);
        step(1);
        pc = press_cnt[3];
        step(20);
        chk("press3_quiet_after_release", press_cnt[3], pc);
        chk("release3_count", rel_cnt[3], 1);
`ifdef BTN_REPEAT_EN
        chk("repeat_pulse_count", rep_stamp.size(), 19);
        if (rep_stamp.size() >= 2)
            chk("repeat_first_gap", rep_stamp[1] - rep_stamp[0], 20);
        for (int k = 2; k < rep_stamp.size(); k++)
            chk("repeat_gap", rep_stamp[k] - rep_stamp[k-1], 8);
`else
        chk("single_press3", press_cnt[3], 1);
        chk("single_press3_stamps", rep_stamp.size(), 1);
`endif
        chk("press_release_same_cycle", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/btn_sw_conditioner.md
Name: btn_sw_conditioner

Overview:
- Input-side front end for the lab boards: synchronizes and debounces the raw push buttons (btnD/btnR/btnU/btnL) and the 8 slide switches.
- Produces clean levels plus one-cycle press, release and change pulses that downstream LED/game FSMs consume directly.
- Also exports the shared millisecond tick so consumers need no private clock divider.

Parameters:
- N_BTN, 4, number of push buttons; bit order {L,U,R,D} = [3:0].
- N_SW, 8, number of slide switches.
- TICK_DIV, 100000, clk cycles per tick (1 ms at 100 MHz); minimum 2.
- DB_TICKS, 10, consecutive ticks an input must differ from its level before the level flips; minimum 1.
- REPEAT_DELAY, 500, ticks a button is held before auto-repeat starts; used only with the optional feature.
- REPEAT_RATE, 100, ticks between auto-repeat pulses; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_raw  in  N_BTN  raw button pins; asynchronous, bouncing
- sw_raw  in  N_SW  raw switch pins; asynchronous, bouncing
- btn_level  out  N_BTN  debounced button state; 1 = pressed
- btn_press  out  N_BTN  one-cycle pulse per debounced 0->1 (and per repeat, if enabled)
- btn_release  out  N_BTN  one-cycle pulse per debounced 1->0
- sw_level  out  N_SW  debounced switch state
- sw_change  out  1  one-cycle pulse when any sw_level bit changes
- tick  out  1  one-cycle pulse every TICK_DIV cycles

Behaviour:
- Reset: all outputs, synchronizer flops, prescaler, per-input counters and FSMs clear to 0. Reset is asynchronous, active-high and usable at any time.
- Synchronizer: two flops per raw input; downstream logic sees only the second flop (sync).
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = 1 for exactly the cycle in which count == TICK_DIV-1, and is registered.

Per-input debounce (identical for each button and switch):
- Counter cnt, width clog2(DB_TICKS+1).
- If sync == level in any cycle, cnt <= 0 immediately, regardless of tick.
- If sync != level and tick = 1: cnt <= cnt+1. When cnt == DB_TICKS-1 on that tick, level <= sync and cnt <= 0 on the same edge.
- Latency from a sync change to the level update: (DB_TICKS-1)*TICK_DIV+1 to DB_TICKS*TICK_DIV cycles. Add 2 cycles from the raw pin.

Button FSM (per button):
- RELEASED -> PRESSED when level rises. btn_press = 1 for that single cycle, registered on the same edge as btn_level.
- PRESSED -> RELEASED when level falls. btn_release = 1 for that single cycle.
- press and release for one button can never occur in the same cycle.
- Different buttons are independent; simultaneous events on several buttons all pulse in the same cycle.

Switches:
- sw_change = 1 for one cycle on any edge where at least one sw_level bit changes.
- Several bits changing on the same edge produce a single pulse.

Boundary conditions:
- Glitch shorter than DB_TICKS consecutive ticks: no level change and no pulse.
- Button held through reset: level is 0 after reset, so a fresh btn_press is issued once debounce completes.
- Reset mid-debounce discards the partial count.

Optional Feature:
- Macro: BTN_REPEAT_EN.
- Defined:
  - The button FSM gains a REPEAT state plus a per-button hold counter.
  - In PRESSED, once level has been high for REPEAT_DELAY ticks: emit btn_press for one cycle on that tick and enter REPEAT.
  - In REPEAT: emit btn_press every REPEAT_RATE ticks.
  - Level falling from PRESSED or REPEAT: go to RELEASED, emit btn_release, clear the hold counter.
- Undefined: no hold counters or REPEAT state are synthesized, and btn_press fires only once per physical press.

Test Plan (TICK_DIV=4, DB_TICKS=3, REPEAT_DELAY=5, REPEAT_RATE=2):
- Clean press: btn_raw=4'b0001 held after reset -> btn_level[0] rises 11-14 cycles later; btn_press[0] high exactly 1 cycle, exactly once; other bits stay 0.
- Bounce: btn_raw[1] toggles every 5 cycles for 40 cycles, then held 1 -> exactly one btn_press[1]; btn_level[1]=1 at the end.
- Glitch: btn_raw[2] high for 6 cycles only -> btn_level[2] stays 0; no press or release pulse.
- Release: from pressed, btn_raw[0] -> 0 -> btn_release[0] one cycle, btn_level[0]=0 within 11-14 cycles, no btn_press.
- Switches: sw_raw 8'h00 -> 8'hA5 -> sw_level=8'hA5 and exactly one sw_change pulse. Then assert rst mid-debounce of 8'hA5 -> 8'h5A -> sw_level=8'h00 immediately, and 8'h5A appears after a full debounce.
- Repeat (BTN_REPEAT_EN): hold btn_raw[3] for 40 ticks -> initial btn_press[3], second pulse 5 ticks after btn_level rises, then one every 2 ticks; no pulses after release. With macro undefined -> a single press only.
